// File: rtl/conv_pkg.sv
// Shared types, widths and the round/saturate helper for the 3x3 convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned IMG_W_DEF  = 64;
  localparam int unsigned IMG_H_DEF  = 64;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned COEF_W_DEF = 5;
  localparam int unsigned ACC_W      = 18;
  localparam int unsigned NPIX       = IMG_W_DEF * IMG_H_DEF;

  // Round half up, arithmetic shift right, then clamp into 0..255.
  function automatic logic [PIX_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                 input int unsigned shift);
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] rnd;
    r   = {acc[ACC_W-1], acc};
    rnd = '0;
    if (shift > 0) rnd = (ACC_W + 1)'(1) << (shift - 1);
    r = r + rnd;
    r = r >>> shift;
    if (r < 0) return '0;
    else if (r > 255) return '1;
    else return r[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_mac_pipe.sv
// Three-stage datapath: products, row sums, round/saturate with output strobe.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int          K0     = 1,
  parameter int          K1     = 2,
  parameter int          K2     = 1,
  parameter int          K3     = 2,
  parameter int          K4     = 4,
  parameter int          K5     = 2,
  parameter int          K6     = 1,
  parameter int          K7     = 2,
  parameter int          K8     = 1,
  parameter int unsigned SHIFT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] pix [9],
  output logic             wr,
  output logic [PIX_W-1:0] pixelw,
  output logic             active,
  output logic             commit
);

  localparam int unsigned PROD_W = 9 + COEF_W;
  localparam logic signed [COEF_W-1:0] KC [9] = '{
    COEF_W'(K0), COEF_W'(K1), COEF_W'(K2),
    COEF_W'(K3), COEF_W'(K4), COEF_W'(K5),
    COEF_W'(K6), COEF_W'(K7), COEF_W'(K8)
  };

  logic signed [PROD_W-1:0] prod [9];
  logic signed [ACC_W-1:0]  row  [3];
  logic signed [ACC_W-1:0]  sum;
  logic                     s1_v;
  logic                     s2_v;

  // S1: nine signed products of zero-extended pixels and kernel coefficients.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) prod[i] <= '0;
    end else begin
      s1_v <= in_valid;
      for (int unsigned i = 0; i < 9; i++)
        prod[i] <= PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(KC[i]);
    end
  end

  // S2: one sum per kernel row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      row[0] <= '0;
      row[1] <= '0;
      row[2] <= '0;
    end else begin
      s2_v   <= s1_v;
      row[0] <= ACC_W'(prod[0]) + ACC_W'(prod[1]) + ACC_W'(prod[2]);
      row[1] <= ACC_W'(prod[3]) + ACC_W'(prod[4]) + ACC_W'(prod[5]);
      row[2] <= ACC_W'(prod[6]) + ACC_W'(prod[7]) + ACC_W'(prod[8]);
    end
  end

  // Final accumulation feeding the output stage.
  always_comb begin
    sum = row[0] + row[1] + row[2];
  end

  // S3: result register holds its value between valid windows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr     <= 1'b0;
      pixelw <= '0;
    end else begin
      wr <= s2_v;
      if (s2_v) pixelw <= round_sat(sum, SHIFT);
    end
  end

  assign active = s1_v | s2_v;
  assign commit = s2_v;

endmodule

// File: rtl/conv3x3_engine.sv
// Frame sequencer for the 3x3 filter: drives the window memory read side and
// hands each returned window to the MAC pipeline.
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int          K0     = 1,
  parameter int          K1     = 2,
  parameter int          K2     = 1,
  parameter int          K3     = 2,
  parameter int          K4     = 4,
  parameter int          K5     = 2,
  parameter int          K6     = 1,
  parameter int          K7     = 2,
  parameter int          K8     = 1,
  parameter int unsigned SHIFT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] p1,
  input  logic [PIX_W-1:0] p2,
  input  logic [PIX_W-1:0] p3,
  input  logic [PIX_W-1:0] p4,
  input  logic [PIX_W-1:0] p5,
  input  logic [PIX_W-1:0] p6,
  input  logic [PIX_W-1:0] p7,
  input  logic [PIX_W-1:0] p8,
  input  logic [PIX_W-1:0] p9,
  output logic             en,
  output logic             rd,
  output logic             wr,
  output logic [PIX_W-1:0] pixelw,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FRAME = IMG_W * IMG_H;
  localparam int unsigned RD_W  = $clog2(FRAME);
  localparam int unsigned WR_W  = $clog2(FRAME + 1);

  state_t           state_q;
  state_t           state_d;
  logic [RD_W-1:0]  rd_cnt;
  logic [WR_W-1:0]  wr_cnt;
  logic             pix_valid;
  logic             pipe_active;
  logic             pipe_commit;
  logic             launch;
  logic [PIX_W-1:0] pix [9];

  // Window pixels in row-major kernel order.
  always_comb begin
    pix[0] = p1;
    pix[1] = p2;
    pix[2] = p3;
    pix[3] = p4;
    pix[4] = p5;
    pix[5] = p6;
    pix[6] = p7;
    pix[7] = p8;
    pix[8] = p9;
  end

  assign launch = (state_q == IDLE) && start;
  assign busy   = (state_q != IDLE);
  assign en     = busy;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and strobes. wr_cnt counts results as they enter the output
  // register, so the drain exit lands on the last wr cycle and done follows it.
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = READ;
      READ: begin
        rd = 1'b1;
        if (rd_cnt == RD_W'(FRAME - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pix_valid && !pipe_active && wr_cnt == WR_W'(FRAME)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read/commit counters and the valid bit for pixels returned by the memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= rd;
      if (launch)  rd_cnt <= '0;
      else if (rd) rd_cnt <= rd_cnt + RD_W'(1);
      if (launch)           wr_cnt <= '0;
      else if (pipe_commit) wr_cnt <= wr_cnt + WR_W'(1);
    end
  end

  conv_mac_pipe #(
    .COEF_W(COEF_W),
    .K0    (K0),
    .K1    (K1),
    .K2    (K2),
    .K3    (K3),
    .K4    (K4),
    .K5    (K5),
    .K6    (K6),
    .K7    (K7),
    .K8    (K8),
    .SHIFT (SHIFT)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(pix_valid),
    .pix     (pix),
    .wr      (wr),
    .pixelw  (pixelw),
    .active  (pipe_active),
    .commit  (pipe_commit)
  );

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench: a default Gaussian engine and a Laplacian engine, each fed by
// a small window-memory model with expected results checked per write.
module tb_conv3x3_engine;

  localparam int GK [9]      = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  localparam int LAP_EXP [3] = '{255, 0, 0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, en_a, rd_a, wr_a, busy_a, done_a;
  logic [7:0] pixelw_a;
  logic [7:0] pa [9];
  logic       start_b, en_b, rd_b, wr_b, busy_b, done_b;
  logic [7:0] pixelw_b;
  logic [7:0] pb [9];

  int total = 0;
  int bad   = 0;
  int mode_a = 0;

  conv3x3_engine dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .p1(pa[0]), .p2(pa[1]), .p3(pa[2]), .p4(pa[3]), .p5(pa[4]),
    .p6(pa[5]), .p7(pa[6]), .p8(pa[7]), .p9(pa[8]),
    .en(en_a), .rd(rd_a), .wr(wr_a), .pixelw(pixelw_a), .busy(busy_a), .done(done_a)
  );

  conv3x3_engine #(
    .K0(0), .K1(-1), .K2(0), .K3(-1), .K4(4), .K5(-1), .K6(0), .K7(-1), .K8(0),
    .SHIFT(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .p1(pb[0]), .p2(pb[1]), .p3(pb[2]), .p4(pb[3]), .p5(pb[4]),
    .p6(pb[5]), .p7(pb[6]), .p8(pb[7]), .p9(pb[8]),
    .en(en_b), .rd(rd_b), .wr(wr_b), .pixelw(pixelw_b), .busy(busy_b), .done(done_b)
  );

  function automatic int pix_a(input int mode, input int n, input int k);
    case (mode)
      0:       return 100;
      1:       return 255;
      default: return (n * 37 + k * 29 + 11) & 255;
    endcase
  endfunction

  function automatic int exp_a(input int mode, input int n);
    int s = 0;
    for (int k = 0; k < 9; k++) s += GK[k] * pix_a(mode, n, k);
    s = (s + 8) >>> 4;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic int pix_b(input int n, input int k);
    case (n % 3)
      0:       return (k == 4) ? 200 : 0;
      1:       return (k == 1) ? 200 : 0;
      default: return 50;
    endcase
  endfunction

  // Window memory for engine A: data appears the cycle after rd.
  int midx_a;
  always @(posedge clk) begin
    if (!rst_n) begin
      midx_a <= 0;
      for (int k = 0; k < 9; k++) pa[k] <= '0;
    end else if (start_a && !busy_a) begin
      midx_a <= 0;
    end else if (rd_a) begin
      for (int k = 0; k < 9; k++) pa[k] <= 8'(pix_a(mode_a, midx_a, k));
      midx_a <= midx_a + 1;
    end
  end

  // Window memory for engine B.
  int midx_b;
  always @(posedge clk) begin
    if (!rst_n) begin
      midx_b <= 0;
      for (int k = 0; k < 9; k++) pb[k] <= '0;
    end else if (start_b && !busy_b) begin
      midx_b <= 0;
    end else if (rd_b) begin
      for (int k = 0; k < 9; k++) pb[k] <= 8'(pix_b(midx_b, k));
      midx_b <= midx_b + 1;
    end
  end

  // Engine A observer: cycle numbers relative to the start edge.
  int cyc_a, nrd_a, nwr_a, errs_a, ndone_a, first_rd_a, first_wr_a, last_wr_a, done_cyc_a, gaps_a;
  always @(negedge clk) begin
    if (rst_n && start_a && !busy_a) begin
      cyc_a = 0; nrd_a = 0; nwr_a = 0; errs_a = 0; ndone_a = 0; gaps_a = 0;
      first_rd_a = -1; first_wr_a = -1; last_wr_a = -1; done_cyc_a = -1;
    end else begin
      cyc_a++;
      if (rd_a) begin
        nrd_a++;
        if (first_rd_a < 0) first_rd_a = cyc_a;
      end
      if (wr_a) begin
        if (first_wr_a < 0) first_wr_a = cyc_a;
        else if (last_wr_a != cyc_a - 1) gaps_a++;
        last_wr_a = cyc_a;
        if (int'(pixelw_a) != exp_a(mode_a, nwr_a)) errs_a++;
        nwr_a++;
      end
      if (done_a) begin
        ndone_a++;
        done_cyc_a = cyc_a;
      end
    end
  end

  // Engine B observer.
  int nrd_b, nwr_b, errs_b, ndone_b;
  int w_b [3];
  always @(negedge clk) begin
    if (rst_n && start_b && !busy_b) begin
      nrd_b = 0; nwr_b = 0; errs_b = 0; ndone_b = 0;
      for (int i = 0; i < 3; i++) w_b[i] = -1;
    end else begin
      if (rd_b) nrd_b++;
      if (wr_b) begin
        if (nwr_b < 3) w_b[nwr_b] = int'(pixelw_b);
        if (int'(pixelw_b) != LAP_EXP[nwr_b % 3]) errs_b++;
        nwr_b++;
      end
      if (done_b) ndone_b++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 6000 && ndone_a == 0; i++) tick();
  endtask

  task automatic frame_checks(input string tag, input int want_done_cyc);
    check({tag, "_nrd"}, nrd_a, 4096);
    check({tag, "_nwr"}, nwr_a, 4096);
    check({tag, "_errs"}, errs_a, 0);
    check({tag, "_ndone"}, ndone_a, 1);
    check({tag, "_done_cyc"}, done_cyc_a, want_done_cyc);
    check({tag, "_busy_after"}, busy_a, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a  = 0;
    repeat (3) tick();
    check("rst_rd", rd_a, 0);
    check("rst_wr", wr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_en", en_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pixelw", pixelw_a, 0);
    rst_n = 1'b1;
    tick();

    // Uniform 100 through the Gaussian: 1600 + 8 >> 4 = 100.
    mode_a = 0;
    pulse_a();
    wait_done_a();
    check("f1_busy_falls", busy_a, 0);
    check("f1_done_low", done_a, 0);
    check("f1_first_rd", first_rd_a, 1);
    check("f1_first_wr", first_wr_a, 5);
    check("f1_gaps", gaps_a, 0);
    check("f1_last_pix", pixelw_a, 100);
    frame_checks("f1", 4101);

    // Uniform 255: 4080 + 8 >> 4 = 255, with spurious starts in READ and DRAIN.
    mode_a = 1;
    pulse_a();
    repeat (100) tick();
    pulse_a();
    for (int i = 0; i < 6000 && rd_a; i++) tick();
    check("f2_drain_busy", busy_a, 1);
    pulse_a();
    wait_done_a();
    repeat (10) tick();
    check("f2_last_pix", pixelw_a, 255);
    frame_checks("f2", 4101);

    // Varying pixels: exercises coefficient placement and rounding.
    mode_a = 2;
    pulse_a();
    wait_done_a();
    frame_checks("f3", 4101);

    // Laplacian, SHIFT=0: centre 200 -> 255, p2=200 -> 0, uniform 50 -> 0.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 6000 && ndone_b == 0; i++) tick();
    check("lap_centre", w_b[0], 255);
    check("lap_p2", w_b[1], 0);
    check("lap_flat", w_b[2], 0);
    check("lap_nrd", nrd_b, 4096);
    check("lap_nwr", nwr_b, 4096);
    check("lap_errs", errs_b, 0);
    check("lap_ndone", ndone_b, 1);

    // Reset in the middle of a frame.
    mode_a = 0;
    pulse_a();
    for (int i = 0; i < 6000 && nrd_a < 2000; i++) tick();
    check("mid_wr_live", wr_a, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_rd", rd_a, 0);
    check("mid_rst_wr", wr_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_en", en_a, 0);
    check("mid_rst_pixelw", pixelw_a, 0);
    rst_n = 1'b1;
    repeat (2300) tick();
    check("mid_no_done", ndone_a, 0);
    check("mid_idle", busy_a, 0);

    // Clean frame after the aborted one.
    mode_a = 2;
    pulse_a();
    wait_done_a();
    check("f4_first_wr", first_wr_a, 5);
    frame_checks("f4", 4101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
